plugin_pixel_stream_proc: RTL and testbench
===========================================

# plugin_pixel_stream_proc

Parametrised memory-to-memory pixel accelerator for the RS5 plugin slot. It reads packed RGB pixels (0xRRGGBB00, one per 32-bit word) through the plugin memory port and converts each to an 8-bit value in a runtime-selected mode. Modes are approximate gray, weighted gray, threshold/binarise and inverted gray. Results are written back one per word or packed several bytes per word, with abort support and a live progress count.

## Interface
- DIM_W, 16: width of the width/height inputs; pixel counters are 2*DIM_W bits.
- PACK, 4: output pixels per written word; legal values are 1 and 4.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  cancels the operation in any non-IDLE state.
- mode  in  2  0 = (R+G+B)>>2, 1 = (77R+150G+29B)>>8, 2 = threshold, 3 = 255 - mode-1 gray; captured at start.
- thresh  in  8  mode 2 cut: output 0xFF if weighted gray >= thresh, else 0x00; captured at start.
- in_base, out_base  in  32  byte addresses, word aligned; captured at start.
- width, height  in  DIM_W  image dimensions; captured at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort takes effect.
- progress  out  2*DIM_W  pixels converted so far.
- mem_req, mem_we  out  1  memory request and write enable.
- mem_addr, mem_wdata  out  32  registered address and write data.
- mem_rdata  in  32  read data; valid in the cycle where mem_req && mem_ready.
- mem_ready  in  1  completes the pending transaction in its cycle.

## Operation
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE, start=1: capture all configuration; clear idx, progress and the pack buffer.
  - If width*height == 0, go to DONE.
  - Otherwise go to READ.
- READ: mem_req=1, mem_we=0, mem_addr = in_base + 4*idx.
  - On mem_ready, register mem_rdata and go to CALC.
- CALC, one cycle: compute the result byte from R=[31:24], G=[23:16], B=[15:8].
  - Place the byte into pack lane idx mod PACK; lane 0 is bits [7:0].
  - Increment progress.
- CALC exit: go to WRITE if the lane was PACK-1 or idx == total-1; otherwise increment idx and go to READ.
- WRITE: mem_req=1, mem_we=1.
  - PACK=4: mem_addr = out_base + 4*(idx/4); wdata = pack buffer, unused lanes zero.
  - PACK=1: mem_addr = out_base + 4*idx; wdata = {g,g,g,8'h00}.
- WRITE exit on mem_ready: clear the pack buffer; go to DONE if idx == total-1, else increment idx and go to READ.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Mode 0 sum is 10 bits.
  - Mode 1 product sum is 16 bits; 77+150+29 = 256, so white maps to 255.
  - total = width*height, 2*DIM_W bits, no overflow possible.
- Abort in READ, CALC, WRITE or DONE: return to IDLE next cycle.
  - mem_req drops next cycle, even mid-transaction.
  - The pending write is discarded.
  - aborted pulses; done does not pulse.
  - progress holds its value until the next start.
- start while busy: ignored.
- abort in IDLE: ignored.
- abort and start together in IDLE: start wins.

## Timing
- Reset values: state IDLE; busy, done, aborted, mem_req, mem_we = 0; mem_addr, mem_wdata, progress = 0.
- start to first mem_req: 1 cycle.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting for mem_ready.
- mem_req deasserts the cycle after mem_ready.
- Per pixel with zero-wait memory:
  - PACK=1: 4 cycles (READ, CALC, WRITE plus one re-entry cycle).
  - PACK=4: 2 cycles per pixel plus 2 per word.
- done rises 1 cycle after the final write's mem_ready.
- Asynchronous reset mid-operation: all outputs go to reset values immediately; no partial write completes after reset.

## Test plan
- PACK=1, mode 0, 1×1 image, pixel 0x30405000, zero-wait memory → one write of 0x30303000 to out_base; done pulses once; progress=1.
- PACK=1, mode 1, pixel 0xFFFFFF00 → write 0xFFFFFF00. Pixel 0xFF000000 → gray 0x4C, write 0x4C4C4C00.
- PACK=4, mode 2, thresh 0x80, 5×1 image, pixels 0x000000 and 0xFFFFFF alternating starting with white → writes 0x00FF00FF then 0x000000FF at out_base+4; exactly 2 writes.
- Mode 3, pixel 0x00000000 → byte 0xFF. Height 0 → no mem_req; done pulses 2 cycles after start.
- mem_ready delayed 3 cycles per access → request signals held stable; results match the zero-wait run.
- abort asserted during the second READ of a 4×1 image → mem_req low next cycle; aborted pulses; no write issued; progress=1; a following start runs correctly.
- reset_n low mid-WRITE → mem_req, busy and progress are 0 immediately; after release the block is in IDLE.

Source files
------------

// File: rtl/plugin_pixel_stream_proc_if.sv
// Memory port bundle between the pixel accelerator and plugin memory.
// master: req/we/addr/wdata out, rdata/ready in; slave is the mirror.
interface plugin_pixel_stream_proc_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/plugin_pixel_stream_proc.sv
// Memory-to-memory RGB to 8-bit pixel converter for the plugin slot.
// Ports: clk, reset_n, start/abort control, mode/thresh/base/size
// config, busy/done/aborted/progress status, mem (master) bus.
module plugin_pixel_stream_proc #(
  parameter int DIM_W = 16,
  parameter int PACK  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [7:0]         thresh,
  input  logic [31:0]        in_base,
  input  logic [31:0]        out_base,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [2*DIM_W-1:0] progress,
  plugin_pixel_stream_proc_if.master mem
);

  localparam int CW = 2 * DIM_W;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [7:0]      thresh_q;
  logic [31:0]     in_base_q;
  logic [31:0]     out_base_q;
  logic [CW-1:0]   total_q;
  logic [CW-1:0]   idx_q;
  logic [23:0]     pix_q;
  logic [31:0]     pack_q;

  logic [CW-1:0]   total_d;
  logic [CW-1:0]   idx_inc;
  logic            last;
  logic [7:0]      r;
  logic [7:0]      g;
  logic [7:0]      b;
  logic [9:0]      sum0;
  logic [15:0]     wsum;
  logic [7:0]      wgray;
  logic [7:0]      res;
  logic [1:0]      lane;
  logic            lane_end;
  logic [31:0]     pack_nxt;
  logic [31:0]     wdata_nxt;
  logic [31:0]     rd_next;
  logic [31:0]     wr_addr;
  logic            unused_lsb;

  function automatic logic [31:0] off(
    input logic [CW-1:0] i
  );
    return 32'(i) << 2;
  endfunction

  assign unused_lsb = ^mem.mem_rdata[7:0];

  assign total_d = CW'(width) * CW'(height);
  assign idx_inc = idx_q + CW'(1);
  assign last    = (idx_q == total_q - CW'(1));

  assign r = pix_q[23:16];
  assign g = pix_q[15:8];
  assign b = pix_q[7:0];

  assign sum0 = 10'(r) + 10'(g) + 10'(b);

  // Weights sum to 256, so the top byte of wsum
  // is a full-scale 0..255 luminance.
  assign wsum = 16'(r) * 16'd77
              + 16'(g) * 16'd150
              + 16'(b) * 16'd29;
  assign wgray = wsum[15:8];

  always_comb begin
    res = 8'h00;
    unique case (mode_q)
      2'd0: res = sum0[9:2];
      2'd1: res = wgray;
      2'd2: res = (wgray >= thresh_q) ? 8'hFF : 8'h00;
      2'd3: res = ~wgray;
      default: res = 8'h00;
    endcase
  end

  assign lane     = (PACK == 1) ? 2'd0 : idx_q[1:0];
  assign lane_end = (PACK == 1) || (lane == 2'd3);

  always_comb begin
    pack_nxt = pack_q;
    pack_nxt[{lane, 3'b000} +: 8] = res;
  end

  assign wdata_nxt = (PACK == 1) ? {res, res, res, 8'h00}
                                 : pack_nxt;

  assign rd_next = in_base_q + off(idx_inc);

  assign wr_addr = (PACK == 1)
                 ? out_base_q + off(idx_q)
                 : out_base_q + off(idx_q >> 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mode_q        <= '0;
      thresh_q      <= '0;
      in_base_q     <= '0;
      out_base_q    <= '0;
      total_q       <= '0;
      idx_q         <= '0;
      pix_q         <= '0;
      pack_q        <= '0;
      progress      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && abort) begin
        // Drop the bus at once; any pending write is lost.
        state       <= IDLE;
        busy        <= 1'b0;
        aborted     <= 1'b1;
        mem.mem_req <= 1'b0;
        mem.mem_we  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              mode_q     <= mode;
              thresh_q   <= thresh;
              in_base_q  <= in_base;
              out_base_q <= out_base;
              total_q    <= total_d;
              idx_q      <= '0;
              progress   <= '0;
              pack_q     <= '0;
              busy       <= 1'b1;
              if (total_d == '0) begin
                state <= DONE;
              end else begin
                state        <= READ;
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= 1'b0;
                mem.mem_addr <= in_base;
              end
            end
          end
          READ: begin
            // Arriving from WRITE the request is re-raised
            // one cycle later; the address is already set.
            if (!mem.mem_req) begin
              mem.mem_req <= 1'b1;
            end else if (mem.mem_ready) begin
              pix_q       <= mem.mem_rdata[31:8];
              mem.mem_req <= 1'b0;
              state       <= CALC;
            end
          end
          CALC: begin
            pack_q   <= pack_nxt;
            progress <= progress + CW'(1);
            if (lane_end || last) begin
              state         <= WRITE;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= wr_addr;
              mem.mem_wdata <= wdata_nxt;
            end else begin
              idx_q        <= idx_inc;
              state        <= READ;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= rd_next;
            end
          end
          WRITE: begin
            if (mem.mem_ready) begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              pack_q      <= '0;
              if (last) begin
                state <= DONE;
              end else begin
                idx_q        <= idx_inc;
                mem.mem_addr <= rd_next;
                state        <= READ;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plugin_pixel_stream_proc.sv
// Directed bench for plugin_pixel_stream_proc, PACK=1 and PACK=4.
// Memory models with programmable wait states and write logging.
module tb_plugin_pixel_stream_proc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  thresh = '0;
  logic [31:0] in_base = 32'h100;
  logic [31:0] out_base = 32'h200;
  logic [15:0] width = '0;
  logic [15:0] height = '0;

  logic        busy1, done1, aborted1;
  logic [31:0] progress1;
  logic        busy4, done4, aborted4;
  logic [31:0] progress4;

  plugin_pixel_stream_proc_if m1 ();
  plugin_pixel_stream_proc_if m4 ();

  plugin_pixel_stream_proc #(.DIM_W(16), .PACK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort),
    .mode(mode), .thresh(thresh), .in_base(in_base),
    .out_base(out_base), .width(width), .height(height),
    .busy(busy1), .done(done1), .aborted(aborted1),
    .progress(progress1), .mem(m1.master)
  );

  plugin_pixel_stream_proc #(.DIM_W(16), .PACK(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort),
    .mode(mode), .thresh(thresh), .in_base(in_base),
    .out_base(out_base), .width(width), .height(height),
    .busy(busy4), .done(done4), .aborted(aborted4),
    .progress(progress4), .mem(m4.master)
  );

  int tests = 0;
  int fails = 0;

  int lat = 0;
  bit stab_on = 1'b0;
  logic [31:0] img [16];

  int cnt1 = 0, cnt4 = 0;
  int rq1 = 0, rq4 = 0;
  int dc1 = 0, dc4 = 0;
  int unst1 = 0, unst4 = 0;
  logic [31:0] wa1[$], wd1[$], wa4[$], wd4[$];

  logic        pend1 = 1'b0, pend4 = 1'b0;
  logic        pwe1, pwe4;
  logic [31:0] pa1, pw1, pa4, pw4;
  logic [31:0] ro1, ro4;

  assign ro1 = m1.mem_addr - in_base;
  assign ro4 = m4.mem_addr - in_base;
  assign m1.mem_rdata = img[ro1[5:2]];
  assign m4.mem_rdata = img[ro4[5:2]];
  assign m1.mem_ready = m1.mem_req && (cnt1 >= lat);
  assign m4.mem_ready = m4.mem_req && (cnt4 >= lat);

  always @(posedge clk) begin
    if (m1.mem_req) rq1++;
    if (done1) dc1++;
    if (m1.mem_req && m1.mem_we && m1.mem_ready) begin
      wa1.push_back(m1.mem_addr);
      wd1.push_back(m1.mem_wdata);
    end
    if (stab_on && pend1 &&
        (!m1.mem_req || m1.mem_we !== pwe1 ||
         m1.mem_addr !== pa1 || m1.mem_wdata !== pw1))
      unst1++;
    pend1 <= m1.mem_req && !m1.mem_ready;
    pwe1  <= m1.mem_we;
    pa1   <= m1.mem_addr;
    pw1   <= m1.mem_wdata;
    cnt1  <= (m1.mem_req && !m1.mem_ready) ? cnt1 + 1 : 0;
  end

  always @(posedge clk) begin
    if (m4.mem_req) rq4++;
    if (done4) dc4++;
    if (m4.mem_req && m4.mem_we && m4.mem_ready) begin
      wa4.push_back(m4.mem_addr);
      wd4.push_back(m4.mem_wdata);
    end
    if (stab_on && pend4 &&
        (!m4.mem_req || m4.mem_we !== pwe4 ||
         m4.mem_addr !== pa4 || m4.mem_wdata !== pw4))
      unst4++;
    pend4 <= m4.mem_req && !m4.mem_ready;
    pwe4  <= m4.mem_we;
    pa4   <= m4.mem_addr;
    pw4   <= m4.mem_wdata;
    cnt4  <= (m4.mem_req && !m4.mem_ready) ? cnt4 + 1 : 0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on one instance; cyc = cycles from the
  // start edge to done high, or -1 on timeout.
  task automatic run(input bit p4, input logic [1:0] md,
                     input logic [15:0] w, input logic [15:0] h,
                     output int cyc);
    mode = md;
    width = w;
    height = h;
    if (p4) start4 = 1'b1;
    else start1 = 1'b1;
    step();
    start1 = 1'b0;
    start4 = 1'b0;
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (p4 ? done4 : done1) begin
        cyc = i;
        break;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n0, d0, r0;
    bit found;

    for (int i = 0; i < 16; i++) img[i] = 32'h0;
    step();
    step();
    chk("rst_busy", {31'b0, busy1}, 32'h0);
    chk("rst_done", {31'b0, done1}, 32'h0);
    chk("rst_aborted", {31'b0, aborted1}, 32'h0);
    chk("rst_req", {31'b0, m1.mem_req}, 32'h0);
    chk("rst_we", {31'b0, m1.mem_we}, 32'h0);
    chk("rst_addr", m1.mem_addr, 32'h0);
    chk("rst_wdata", m1.mem_wdata, 32'h0);
    chk("rst_progress", progress1, 32'h0);
    reset_n = 1'b1;
    step();

    // mode 0, 1x1, PACK=1
    img[0] = 32'h30405000;
    n0 = wa1.size();
    d0 = dc1;
    run(1'b0, 2'd0, 16'd1, 16'd1, cyc);
    chk("m0_cycles", 32'(cyc), 32'd4);
    step();
    chk("m0_nwr", 32'(wa1.size() - n0), 32'd1);
    if (wa1.size() > n0) begin
      chk("m0_addr", wa1[n0], 32'h200);
      chk("m0_data", wd1[n0], 32'h30303000);
    end
    chk("m0_progress", progress1, 32'd1);
    chk("m0_done_once", 32'(dc1 - d0), 32'd1);
    chk("m0_idle", {31'b0, busy1}, 32'h0);

    // mode 1, white and red
    img[0] = 32'hFFFFFF00;
    n0 = wa1.size();
    run(1'b0, 2'd1, 16'd1, 16'd1, cyc);
    chk("m1w_done", 32'(cyc >= 0), 32'd1);
    step();
    if (wa1.size() > n0) chk("m1w_data", wd1[n0], 32'hFFFFFF00);
    else chk("m1w_nwr", 32'(wa1.size() - n0), 32'd1);

    img[0] = 32'hFF000000;
    n0 = wa1.size();
    run(1'b0, 2'd1, 16'd1, 16'd1, cyc);
    chk("m1r_done", 32'(cyc >= 0), 32'd1);
    step();
    if (wa1.size() > n0) chk("m1r_data", wd1[n0], 32'h4C4C4C00);
    else chk("m1r_nwr", 32'(wa1.size() - n0), 32'd1);

    // mode 3, black -> 0xFF
    img[0] = 32'h00000000;
    n0 = wa1.size();
    run(1'b0, 2'd3, 16'd1, 16'd1, cyc);
    chk("m3_done", 32'(cyc >= 0), 32'd1);
    step();
    if (wa1.size() > n0) chk("m3_data", wd1[n0], 32'hFFFFFF00);
    else chk("m3_nwr", 32'(wa1.size() - n0), 32'd1);

    // zero height: no bus traffic, done one edge after DONE
    r0 = rq1;
    d0 = dc1;
    run(1'b0, 2'd0, 16'd5, 16'd0, cyc);
    chk("h0_cycles", 32'(cyc), 32'd1);
    step();
    chk("h0_noreq", 32'(rq1 - r0), 32'd0);
    chk("h0_done_once", 32'(dc1 - d0), 32'd1);

    // PACK=4 threshold, 5x1 alternating white/black
    thresh = 8'h80;
    for (int i = 0; i < 5; i++)
      img[i] = (i % 2 == 0) ? 32'hFFFFFF00 : 32'h00000000;
    n0 = wa4.size();
    run(1'b1, 2'd2, 16'd5, 16'd1, cyc);
    chk("p4_cycles", 32'(cyc), 32'd14);
    step();
    chk("p4_nwr", 32'(wa4.size() - n0), 32'd2);
    if (wa4.size() >= n0 + 2) begin
      chk("p4_a0", wa4[n0], 32'h200);
      chk("p4_d0", wd4[n0], 32'h00FF00FF);
      chk("p4_a1", wa4[n0+1], 32'h204);
      chk("p4_d1", wd4[n0+1], 32'h000000FF);
    end
    chk("p4_progress", progress4, 32'd5);

    // three wait states per access, request must hold
    lat = 3;
    stab_on = 1'b1;
    img[0] = 32'h30405000;
    n0 = wa1.size();
    run(1'b0, 2'd0, 16'd1, 16'd1, cyc);
    chk("lat1_done", 32'(cyc >= 0), 32'd1);
    step();
    if (wa1.size() > n0) chk("lat1_data", wd1[n0], 32'h30303000);
    else chk("lat1_nwr", 32'(wa1.size() - n0), 32'd1);

    for (int i = 0; i < 5; i++)
      img[i] = (i % 2 == 0) ? 32'hFFFFFF00 : 32'h00000000;
    n0 = wa4.size();
    run(1'b1, 2'd2, 16'd5, 16'd1, cyc);
    chk("lat4_done", 32'(cyc >= 0), 32'd1);
    step();
    chk("lat4_nwr", 32'(wa4.size() - n0), 32'd2);
    if (wa4.size() >= n0 + 2) begin
      chk("lat4_d0", wd4[n0], 32'h00FF00FF);
      chk("lat4_a1", wa4[n0+1], 32'h204);
      chk("lat4_d1", wd4[n0+1], 32'h000000FF);
    end
    stab_on = 1'b0;
    chk("stable1", 32'(unst1), 32'd0);
    chk("stable4", 32'(unst4), 32'd0);

    // abort during second read of a 4x1 image
    for (int i = 0; i < 4; i++) img[i] = 32'h30405000;
    n0 = wa4.size();
    d0 = dc4;
    mode = 2'd0;
    width = 16'd4;
    height = 16'd1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m4.mem_req && !m4.mem_we && m4.mem_addr == 32'h104) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("ab_reached", {31'b0, found}, 32'h1);
    abort = 1'b1;
    step();
    chk("ab_req", {31'b0, m4.mem_req}, 32'h0);
    chk("ab_pulse", {31'b0, aborted4}, 32'h1);
    chk("ab_busy", {31'b0, busy4}, 32'h0);
    abort = 1'b0;
    step();
    chk("ab_pulse_end", {31'b0, aborted4}, 32'h0);
    step();
    step();
    chk("ab_progress", progress4, 32'd1);
    chk("ab_nwr", 32'(wa4.size() - n0), 32'd0);
    chk("ab_nodone", 32'(dc4 - d0), 32'd0);

    lat = 0;
    img[0] = 32'h30405000;
    n0 = wa4.size();
    run(1'b1, 2'd0, 16'd1, 16'd1, cyc);
    chk("ab_rerun_done", 32'(cyc >= 0), 32'd1);
    step();
    chk("ab_rerun_nwr", 32'(wa4.size() - n0), 32'd1);
    if (wa4.size() > n0) begin
      chk("ab_rerun_addr", wa4[n0], 32'h200);
      chk("ab_rerun_data", wd4[n0], 32'h00000030);
    end

    // asynchronous reset while a write is pending
    lat = 3;
    n0 = wa1.size();
    mode = 2'd0;
    width = 16'd1;
    height = 16'd1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m1.mem_req && m1.mem_we) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("rw_reached", {31'b0, found}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_req", {31'b0, m1.mem_req}, 32'h0);
    chk("rw_busy", {31'b0, busy1}, 32'h0);
    chk("rw_progress", progress1, 32'h0);
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    chk("rw_idle", {31'b0, busy1}, 32'h0);
    chk("rw_nwr", 32'(wa1.size() - n0), 32'd0);

    lat = 0;
    img[0] = 32'h30405000;
    n0 = wa1.size();
    run(1'b0, 2'd0, 16'd1, 16'd1, cyc);
    chk("rw_rerun_cycles", 32'(cyc), 32'd4);
    step();
    if (wa1.size() > n0) chk("rw_rerun_data", wd1[n0], 32'h30303000);
    else chk("rw_rerun_nwr", 32'(wa1.size() - n0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
